// File: rtl/data_path.sv
// data_path: single-bus 32-bit datapath for the teaching CPU.
// An external control unit selects one bus driver and any number of load
// enables each cycle. The ALU takes RY as operand A and the bus as operand B,
// and writes a double-width result into Z.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       ops,
  input  logic             RAout,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             RYout,
  input  logic             RZHIout,
  input  logic             RZLOout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             MDRout,
  input  logic             PORTout,
  input  logic             RAin,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             RYin,
  input  logic             RZin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             MDRin,
  input  logic             PORTin,
  input  logic             Read,
  output logic [WIDTH-1:0] bus_out
);

  localparam int SHW = $clog2(WIDTH);

  logic [15:0]        r_out_sel;
  logic [15:0]        r_in_en;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   r_d [16];
  logic [WIDTH-1:0]   ra_q, ra_d, ry_q, ry_d, pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mdr_q, mdr_d, port_q, port_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  assign r_out_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in_en   = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // ALU: A = RY, B = bus. Only mul/div populate the upper half of the result.
  function automatic logic [2*WIDTH-1:0] alu_eval(input logic [4:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0]            sh;
    logic signed [WIDTH-1:0]   sa, sb, quo, rem;
    logic signed [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0]        dbl, rot;
    logic [2*WIDTH-1:0]        res;
    sh   = b[SHW-1:0];
    sa   = a;
    sb   = b;
    dbl  = {a, a};
    rot  = '0;
    quo  = '0;
    rem  = '0;
    prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    res  = '0;
    case (op)
      5'b00011: res[WIDTH-1:0] = a + b;
      5'b00100: res[WIDTH-1:0] = a - b;
      5'b00101: res[WIDTH-1:0] = a & b;
      5'b00110: res[WIDTH-1:0] = a | b;
      5'b00111: begin
        // Low half of {a,a} shifted right is a rotated right.
        rot = dbl >> sh;
        res[WIDTH-1:0] = rot[WIDTH-1:0];
      end
      5'b01000: begin
        // High half of {a,a} shifted left is a rotated left.
        rot = dbl << sh;
        res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
      end
      5'b01001: res[WIDTH-1:0] = a >> sh;
      5'b01010: res[WIDTH-1:0] = sa >>> sh;
      5'b01011: res[WIDTH-1:0] = a << sh;
      5'b01111: res = prod;
      5'b10000: begin
        // Divide by zero leaves the whole result at zero.
        if (b != '0) begin
          quo = sa / sb;
          rem = sa % sb;
          res = {rem, quo};
        end
      end
      5'b10001: res[WIDTH-1:0] = -b;
      5'b10010: res[WIDTH-1:0] = ~b;
      5'b10011: res[WIDTH-1:0] = b + WIDTH'(1);
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Bus mux: assignments run lowest to highest priority, so the last match wins.
  always_comb begin
    bus = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_out_sel[i]) bus = r_q[i];
    end
    if (RAout)   bus = ra_q;
    if (RYout)   bus = ry_q;
    if (PORTout) bus = port_q;
    if (LOout)   bus = lo_q;
    if (HIout)   bus = hi_q;
    if (IRout)   bus = ir_q;
    if (PCout)   bus = pc_q;
    if (RZHIout) bus = z_q[2*WIDTH-1:WIDTH];
    if (RZLOout) bus = z_q[WIDTH-1:0];
    if (MDRout)  bus = mdr_q;
  end

  assign bus_out = bus;
  assign alu_res = alu_eval(ops, ry_q, bus);

  // Next-state: each register loads its source when enabled, otherwise holds.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = r_in_en[i] ? bus : r_q[i];
    end
    ra_d   = RAin   ? bus : ra_q;
    ry_d   = RYin   ? bus : ry_q;
    pc_d   = PCin   ? bus : pc_q;
    ir_d   = IRin   ? bus : ir_q;
    hi_d   = HIin   ? bus : hi_q;
    lo_d   = LOin   ? bus : lo_q;
    port_d = PORTin ? bus : port_q;
    mdr_d  = MDRin  ? (Read ? Mdatain : bus) : mdr_q;
    z_d    = RZin   ? alu_res : z_q;
  end

  // Register bank with asynchronous clear overriding any load.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= '0;
      end
      ra_q   <= '0;
      ry_q   <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      port_q <= '0;
      mdr_q  <= '0;
      z_q    <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= r_d[i];
      end
      ra_q   <= ra_d;
      ry_q   <= ry_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      port_q <= port_d;
      mdr_q  <= mdr_d;
      z_q    <= z_d;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: the stimulus pushes expected bus values,
// and a monitor on the falling edge pops and compares them.
module tb_data_path;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic [4:0]  ops;
  logic [15:0] rout, rin;
  logic RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, PORTout;
  logic RAin, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, PORTin, Read;
  logic [31:0] bus_out;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        obs_vld;
  int          n_vec;
  int          n_bad;

  data_path #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .ops(ops),
    .RAout(RAout),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .RYout(RYout), .RZHIout(RZHIout), .RZLOout(RZLOout), .PCout(PCout),
    .IRout(IRout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .PORTout(PORTout),
    .RAin(RAin),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .RYin(RYin), .RZin(RZin), .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin),
    .MDRin(MDRin), .PORTin(PORTin), .Read(Read),
    .bus_out(bus_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one expected bus value per flagged cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (obs_vld) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: bus_out=%h with no expected value", bus_out);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (bus_out !== e) begin
          n_bad++;
          $display("FAIL %s: bus_out=%h expected=%h", n, bus_out, e);
        end
      end
    end
  end

  task automatic idle();
    rout = '0; rin = '0; ops = 5'b0; Read = 1'b0;
    RAout = 0; RYout = 0; RZHIout = 0; RZLOout = 0; PCout = 0;
    IRout = 0; HIout = 0; LOout = 0; MDRout = 0; PORTout = 0;
    RAin = 0; RYin = 0; RZin = 0; PCin = 0; IRin = 0;
    HIin = 0; LOin = 0; MDRin = 0; PORTin = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    obs_vld = 1'b0;
    idle();
  endtask

  task automatic chk(input string n, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
    obs_vld = 1'b1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  // Run one ALU op with B = MDR, then read Z low on the next cycle.
  task automatic alu_lo(input string n, input logic [4:0] op, input logic [31:0] v);
    MDRout = 1; ops = op; RZin = 1; tick();
    RZLOout = 1; chk(n, v); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; obs_vld = 1'b0; Mdatain = '0;
    idle();
    clear = 1'b1;
    @(posedge clock); #1;
    chk("reset_bus", 32'h0); tick();
    clear = 1'b0;

    // Memory load path and idle bus
    Mdatain = 32'h0000BEEF; Read = 1; MDRin = 1; chk("idle_bus", 32'h0); tick();
    MDRout = 1; rin[2] = 1; chk("mdr_read", 32'h0000BEEF); tick();
    rout[2] = 1; chk("r2_load", 32'h0000BEEF); tick();
    Mdatain = 32'h12345678; Read = 0; rout[2] = 1; MDRin = 1; tick();
    MDRout = 1; chk("mdr_from_bus", 32'h0000BEEF); tick();

    // Multiple load enables take the same bus value
    load_mdr(32'h5A5A_0F0F);
    MDRout = 1; IRin = 1; PORTin = 1; RAin = 1; tick();
    IRout = 1; chk("ir_multi", 32'h5A5A_0F0F); tick();
    PORTout = 1; chk("port_multi", 32'h5A5A_0F0F); tick();
    RAout = 1; chk("ra_multi", 32'h5A5A_0F0F); tick();

    // AND
    load_mdr(32'hF0F0_00FF);
    MDRout = 1; rin[2] = 1; RYin = 1; tick();
    load_mdr(32'h0FF0_0F0F);
    MDRout = 1; rin[3] = 1; tick();
    rout[3] = 1; ops = 5'b00101; RZin = 1; chk("r3_load", 32'h0FF0_0F0F); tick();
    RZLOout = 1; chk("and_lo", 32'h00F0_000F); tick();
    RZHIout = 1; chk("and_hi", 32'h0); tick();

    // PC increment through Z
    load_mdr(32'd7);
    MDRout = 1; PCin = 1; tick();
    PCout = 1; ops = 5'b10011; RZin = 1; chk("pc_7", 32'd7); tick();
    RZLOout = 1; PCin = 1; chk("inc_lo", 32'd8); tick();
    PCout = 1; chk("pc_8", 32'd8); tick();

    // Signed multiply into HI/LO
    load_mdr(32'hFFFF_FFFD);
    MDRout = 1; RYin = 1; tick();
    load_mdr(32'd5);
    MDRout = 1; ops = 5'b01111; RZin = 1; tick();
    RZHIout = 1; HIin = 1; chk("mul_hi", 32'hFFFF_FFFF); tick();
    RZLOout = 1; LOin = 1; chk("mul_lo", 32'hFFFF_FFF1); tick();
    HIout = 1; chk("hi_reg", 32'hFFFF_FFFF); tick();
    LOout = 1; chk("lo_reg", 32'hFFFF_FFF1); tick();

    // Signed divide, then divide by zero (R0 still holds 0)
    load_mdr(32'd17);
    MDRout = 1; RYin = 1; tick();
    load_mdr(32'd5);
    MDRout = 1; ops = 5'b10000; RZin = 1; tick();
    RZLOout = 1; chk("div_quo", 32'd3); tick();
    RZHIout = 1; chk("div_rem", 32'd2); tick();
    rout[0] = 1; ops = 5'b10000; RZin = 1; tick();
    RZLOout = 1; chk("div0_lo", 32'h0); tick();
    RZHIout = 1; chk("div0_hi", 32'h0); tick();

    // Bus priority
    load_mdr(32'h0000_A5A5);
    MDRout = 1; rin[1] = 1; tick();
    load_mdr(32'h0000_1234);
    MDRout = 1; rout[1] = 1; chk("prio_mdr_r1", 32'h0000_1234); tick();
    rout[1] = 1; chk("r1_alone", 32'h0000_A5A5); tick();
    RZLOout = 1; PCout = 1; rout[1] = 1; chk("prio_zlo_pc", 32'h0); tick();
    HIout = 1; LOout = 1; chk("prio_hi_lo", 32'hFFFF_FFFF); tick();
    RYout = 1; rout[1] = 1; chk("prio_ry_r1", 32'd17); tick();

    // Shifts and remaining ops with RY = 8000_0001, B = 1
    load_mdr(32'h8000_0001);
    MDRout = 1; RYin = 1; tick();
    load_mdr(32'h0000_0001);
    alu_lo("shra", 5'b01010, 32'hC000_0000);
    alu_lo("ror",  5'b00111, 32'hC000_0000);
    alu_lo("shr",  5'b01001, 32'h4000_0000);
    alu_lo("rol",  5'b01000, 32'h0000_0003);
    alu_lo("shl",  5'b01011, 32'h0000_0002);
    alu_lo("add",  5'b00011, 32'h8000_0002);
    alu_lo("sub",  5'b00100, 32'h8000_0000);
    alu_lo("or",   5'b00110, 32'h8000_0001);
    alu_lo("neg",  5'b10001, 32'hFFFF_FFFF);
    alu_lo("not",  5'b10010, 32'hFFFF_FFFE);
    rout[0] = 1; ops = 5'b01001; RZin = 1; tick();
    RZLOout = 1; chk("shr_by_0", 32'h8000_0001); tick();
    alu_lo("bad_op", 5'b11111, 32'h0);

    // Asynchronous clear in mid-cycle, observed before the next clock edge
    alu_lo("z_before_clear", 5'b00011, 32'h8000_0002);
    rout[1] = 1; chk("clear_async_r1", 32'h0);
    #1 clear = 1'b1;
    #5 clear = 1'b0;
    tick();
    PCout = 1; chk("clear_pc", 32'h0); tick();
    RZLOout = 1; chk("clear_zlo", 32'h0); tick();
    MDRout = 1; chk("clear_mdr", 32'h0); tick();

    tick();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
